// File: rtl/cas_recorder.sv
// cas_recorder: decodes the CoCo cassette DAC FSK stream into leader-aligned bytes written to tape SRAM.
// Optional `define CAS_REC_TIMEOUT_EN drops lock as soon as an inter-block gap exceeds MAX_PER ticks.
module cas_recorder #(
  parameter int TICK_DIV = 57,
  parameter int HI_TH    = 36,
  parameter int LO_TH    = 28,
  parameter int BIT_TH   = 625,
  parameter int MIN_PER  = 200,
  parameter int MAX_PER  = 1500
) (
  input  logic        clk,
  input  logic        COCO_RESET_N,
  input  logic        en,
  input  logic        clear,
  input  logic [5:0]  cas_in,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_wr,
  output logic [15:0] rec_len,
  output logic        locked,
  output logic        overflow
);
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam int PW = $clog2(MAX_PER + 2);
  localparam logic [PW-1:0] PER_SAT = PW'(MAX_PER + 1);
  typedef enum logic [1:0] {IDLE, HUNT, LOCKED} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div;
  logic [PW-1:0] per;
  logic [7:0] shift, shift_nx;
  logic [2:0] bits;
  logic cmp, cmp_q, armed, done, tick, rise, idle, ev, valid, bit_v, to;
  always_comb begin
    tick = div == DW'(TICK_DIV - 1);
    rise = cmp & ~cmp_q;
    idle = !en || state == IDLE;
    ev = rise && armed && !idle;
    valid = per >= PW'(MIN_PER) && per <= PW'(MAX_PER);
    bit_v = per < PW'(BIT_TH);
    shift_nx = {bit_v, shift[7:1]};
`ifdef CAS_REC_TIMEOUT_EN
    to = state == LOCKED && per == PER_SAT;
`else
    to = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge COCO_RESET_N)
    if (!COCO_RESET_N) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = !en ? IDLE :
               state == IDLE ? HUNT :
               (ev && !valid) || to ? HUNT :
               state == HUNT && ev && shift_nx == 8'h55 ? LOCKED : state;
  always_comb locked = state == LOCKED;
  always_ff @(posedge clk or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      div <= '0;
      cmp <= 1'b0;
      cmp_q <= 1'b0;
      per <= '0;
      armed <= 1'b0;
      shift <= '0;
      bits <= '0;
      done <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wr <= 1'b0;
      rec_len <= '0;
      overflow <= 1'b0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      cmp <= cas_in >= 6'(HI_TH) ? 1'b1 : cas_in <= 6'(LO_TH) ? 1'b0 : cmp;
      cmp_q <= cmp;
      done <= 1'b0;
      if (idle) begin
        per <= '0;
        armed <= 1'b0;
        shift <= '0;
        bits <= '0;
      end else begin
        per <= rise ? '0 : tick && per != PER_SAT ? per + 1'b1 : per;
        if (rise) armed <= 1'b1;
        if (to || (ev && !valid)) begin
          shift <= '0;
          bits <= '0;
        end else if (ev) begin
          shift <= shift_nx;
          if (state == LOCKED) begin
            bits <= bits + 3'd1;
            done <= bits == 3'd7;
          end else if (shift_nx == 8'h55) begin
            bits <= '0;
            done <= 1'b1;
          end
        end
      end
      // the strobe is one cycle wide; clear overrides a coincident write
      ram_wr <= 1'b0;
      if (clear) begin
        rec_len <= '0;
        ram_addr <= '0;
        overflow <= 1'b0;
      end else if (done) begin
        if (rec_len == 16'hFFFF) overflow <= 1'b1;
        else begin
          ram_wr <= 1'b1;
          ram_addr <= rec_len;
          ram_data <= shift;
          rec_len <= rec_len + 16'd1;
        end
      end
    end
  end
endmodule

// File: doc/cas_recorder.md
Name: cas_recorder

Overview:
- Cassette recorder: the decode direction of the tape path. The existing cassette player turns stored bytes into the 1200/2400 Hz FSK bit stream.
- This block samples the CoCo 6-bit cassette DAC output while the motor relay is on.
- It recovers bits from full-cycle periods, byte-aligns on the 0x55 leader, and writes decoded bytes into the tape SRAM (same COCO_SRAM, byte-wide, 16-bit address) for later saving as a .CAS image.
- Sits beside the cassette player in the emu top level, on clk_sys.

Parameters:
- TICK_DIV, 57, clk cycles per 1 us tick (57 MHz clk_sys).
- HI_TH, 36, DAC level at or above which the comparator goes high.
- LO_TH, 28, DAC level at or below which the comparator goes low.
- BIT_TH, 625, period in ticks: below it a cycle is bit 1 (2400 Hz), at or above it bit 0 (1200 Hz).
- MIN_PER, 200, periods below this (ticks) are invalid.
- MAX_PER, 1500, periods above this (ticks) are invalid.

Ports:
- clk  in  1  system clock (clk_sys).
- COCO_RESET_N  in  1  asynchronous active-low reset.
- en  in  1  cassette motor relay (cas_relay); 1 = recording enabled.
- clear  in  1  one-cycle pulse: rewind the record pointer to 0.
- cas_in  in  6  CoCo cassette DAC sample.
- ram_addr  out  16  SRAM write address.
- ram_data  out  8  SRAM write data.
- ram_wr  out  1  one-cycle write strobe; ram_addr/ram_data valid in the same cycle.
- rec_len  out  16  number of bytes written since the last clear.
- locked  out  1  1 while in the LOCKED state.
- overflow  out  1  sticky: a byte was decoded with the buffer full.

Behaviour:
- Reset values: ram_addr=0, ram_data=0, ram_wr=0, rec_len=0, locked=0, overflow=0. Internal: comparator=0, tick counter=0, period counter=0, shift register=0, bit count=0, state=IDLE.

Tick and period counting:
- tick pulses once every TICK_DIV clk cycles; its divider free-runs.
- Comparator has hysteresis: it sets when cas_in>=HI_TH and clears when cas_in<=LO_TH; otherwise it holds.
- Period counter increments on each tick and saturates at MAX_PER+1.
- A rising edge of the comparator (registered, 0->1) ends a period. On that edge the period value is evaluated and the counter restarts at 0 in the same cycle.
- Period classification: invalid if <MIN_PER or >MAX_PER; bit=1 if <BIT_TH; otherwise bit=0.
- The first rising edge after leaving IDLE only starts the counter; it produces no bit.

Bit assembly:
- Bits are shifted in LSB-first: shift <= {bit, shift[7:1]}.

States:
- IDLE: entered whenever en=0 (from any state, in that cycle). Counters are held at 0; no bits are produced. en=1 moves to HUNT.
- HUNT: every valid bit shifts in. When the shift register equals 0x55 after a shift, go to LOCKED with bit count=0. The 0x55 that produced lock is itself written as the first byte, so leader bytes are preserved.
- LOCKED: every valid bit shifts in and bit count increments. When the 8th bit arrives, the byte is written and bit count returns to 0.
- Any invalid period in HUNT or LOCKED returns to HUNT. The partial byte is discarded and never written; the shift register is cleared to 0.

Byte write:
- Write happens on the cycle after the completing bit: ram_data=byte, ram_addr=rec_len, ram_wr=1 for exactly 1 cycle, then rec_len increments.
- Latency from the rising edge that completes a byte to ram_wr is 2 clk cycles.
- rec_len saturates at 0xFFFF. A byte decoded when rec_len=0xFFFF gets no ram_wr and sets overflow.

clear:
- Sets rec_len=0, ram_addr=0, overflow=0; the state is unaffected.
- If clear coincides with a byte write, clear wins and that write is suppressed.

Reset mid-operation:
- Asynchronous; all registers return to reset values immediately and ram_wr drops to 0 the same instant.

Optional Feature:
- Macro: CAS_REC_TIMEOUT_EN.
- When defined: in LOCKED, if the period counter reaches MAX_PER+1 (no edge for more than 1500 ticks, i.e. an inter-block gap), the block returns to HUNT and discards the partial byte. No byte is written. The next block re-locks on its leader.
- When undefined: a silent gap is detected only at the next edge, whose period (saturated value) is then classified invalid. The final effect is the same; only the timing of the HUNT transition differs.

Test Plan:
- Reset/idle: en=0, cas_in toggling at 2400 Hz -> no ram_wr, locked=0, rec_len=0; reset values as listed above.
- Leader lock: en=1, feed 0x55 x4 at 833/417 us cycles, then 0x3C, 0xAA -> locked rises after the first 0x55. Writes are 0x55,0x55,0x55,0x55,0x3C,0xAA at addresses 0..5, each ram_wr exactly 1 cycle wide, 2 clk after the completing edge; rec_len=6.
- Hysteresis and classification: cas_in swinging 30<->33 -> no edges. A 624-tick period gives bit 1; a 625-tick period gives bit 0.
- Invalid period: while locked, after 3 bits of a byte inject a 150-tick cycle -> HUNT, locked=0, no partial write. Re-lock on the next 0x55; writes resume at the next address.
- Overflow/clear: preload rec_len to 0xFFFF via 65535 bytes (or force), decode 1 byte -> no ram_wr, overflow=1. Pulse clear -> rec_len=0, overflow=0; the next byte is written at addr 0.
- Motor off / gap: drop en mid-byte -> IDLE, no write. With CAS_REC_TIMEOUT_EN, 2 ms of silence while locked -> locked=0 at tick 1501. Without the macro, locked stays 1 until the next edge.
